regfile_mp: RTL

Parametrised multi-port register file, the successor to the single-write/dual-read regfile used by the multi-cycle MIPS core. It adds configurable read and write port counts, an optional hard-wired zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard for outstanding multi-cycle writes such as loads. It sits between decode (reads, reserve) and writeback (writes) in the core datapath.

---
 rtl/regfile_pkg.sv | 39 +++
 rtl/regfile_scoreboard.sv | 68 ++++++
 rtl/regfile_mp.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default geometry (32 x 32-bit)
//   MAX_WR                          : widest write-port count supported
//   reg_addr_t / reg_data_t         : address and data types at default geometry
//   wr_sel_t                        : result of write-port arbitration
//   wr_winner()                     : highest-index hitting write port wins
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_WR         = 2;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // hit  : at least one enabled write port targets the address
  // port : index of the winning port (meaningful only when hit=1)
  typedef struct packed {
    logic       hit;
    logic [0:0] port;
  } wr_sel_t;

  // Given one hit bit per write port for a single address, pick the winner.
  // The loop runs upward so the highest-index hitting port overrides lower
  // ones; the storage write path and the read bypass both rely on this so
  // they always agree on which data lands.
  function automatic wr_sel_t wr_winner(input logic [MAX_WR-1:0] hit);
    wr_sel_t sel;
    sel = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (hit[j]) begin
        sel.hit  = 1'b1;
        sel.port = 1'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for outstanding multi-cycle
// producers (e.g. loads reserved at decode, completed at writeback).
// Ports:
//   clk      : clock, state updates on rising edge
//   rst      : asynchronous active-low reset, clears every busy bit
//   rsv_en   : reserve request, marks rsv_addr busy
//   rsv_addr : register to reserve
//   wr_hit   : one bit per register, an enabled (non-dropped) write lands there
//   busy     : current busy bits
//   busy_cnt : registered population count of busy bits after the edge
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rsv_en,
  input  logic [ADDR_WIDTH-1:0]      rsv_addr,
  input  logic [(2**ADDR_WIDTH)-1:0] wr_hit,
  output logic [(2**ADDR_WIDTH)-1:0] busy,
  output logic [ADDR_WIDTH:0]        busy_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0]    busy_reg;
  logic [DEPTH-1:0]    busy_next;
  logic [DEPTH-1:0]    rsv_hit;
  logic [ADDR_WIDTH:0] busy_cnt_reg;
  logic [ADDR_WIDTH:0] busy_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      // Register 0 can never become busy when it is hard-wired to zero.
      localparam bit LOCKED = (ZERO_REG != 0) && (gi == 0);

      assign rsv_hit[gi] = rsv_en && (rsv_addr == ADDR_WIDTH'(gi)) && !LOCKED;

      // A reservation in the same cycle as a write is a new outstanding
      // producer, so set takes priority over the write's clear.
      assign busy_next[gi] = rsv_hit[gi] | (busy_reg[gi] & ~wr_hit[gi]);
    end
  endgenerate

  always_comb begin
    busy_cnt_next = '0;
    for (int a = 0; a < DEPTH; a++) begin
      busy_cnt_next = busy_cnt_next + {{ADDR_WIDTH{1'b0}}, busy_next[a]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign busy     = busy_reg;
  assign busy_cnt = busy_cnt_reg;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with optional hard-wired
// zero register, same-cycle write-to-read bypass and a busy scoreboard.
// Ports:
//   clk         : clock, all state updates on rising edge
//   rst         : asynchronous active-low reset
//   ra          : NUM_RD read addresses, port i in slice i
//   rd          : NUM_RD read data words, combinational
//   rd_busy     : per read port, target register has an outstanding reservation
//   we/wa/wd    : NUM_WR write enables, addresses, data
//   rsv_en      : reserve request for rsv_addr
//   rsv_addr    : register to reserve
//   wr_conflict : registered pulse, two write ports hit the same address last cycle
//   busy_cnt    : registered count of busy registers
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wd,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         wr_conflict,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  genvar gi;

  generate
    if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || NUM_RD < 1 || NUM_RD > 4 ||
        NUM_WR < 1 || NUM_WR > MAX_WR ||
        (ZERO_REG != 0 && ZERO_REG != 1) || (BYPASS != 0 && BYPASS != 1)) begin : g_bad_param
      $error("regfile_mp: illegal parameter combination");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [ADDR_WIDTH-1:0] wa_arr  [MAX_WR];
  logic [DATA_WIDTH-1:0] wd_arr  [MAX_WR];
  logic [MAX_WR-1:0]     we_eff;
  wr_sel_t               sel_arr [DEPTH];
  logic [DEPTH-1:0]      wr_hit;
  logic [DEPTH-1:0]      busy;
  logic                  conflict_reg;
  logic                  conflict_next;

  // Write ports are padded to MAX_WR so arbitration is always the same
  // shape; absent ports never enable. we_eff already excludes writes that
  // get dropped at the zero register, so nothing downstream rechecks it.
  generate
    for (gi = 0; gi < MAX_WR; gi++) begin : g_wport
      if (gi < NUM_WR) begin : g_real
        assign wa_arr[gi] = wa[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wd_arr[gi] = wd[gi*DATA_WIDTH +: DATA_WIDTH];
        assign we_eff[gi] = we[gi] && !((ZERO_REG != 0) && (wa_arr[gi] == '0));
      end else begin : g_pad
        assign wa_arr[gi] = '0;
        assign wd_arr[gi] = '0;
        assign we_eff[gi] = 1'b0;
      end
    end
  endgenerate

  // Per-register write arbitration.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_warb
      logic [MAX_WR-1:0] port_hit;
      always_comb begin
        port_hit = '0;
        for (int j = 0; j < MAX_WR; j++) begin
          port_hit[j] = we_eff[j] && (wa_arr[j] == ADDR_WIDTH'(gi));
        end
      end
      assign sel_arr[gi] = wr_winner(port_hit);
      assign wr_hit[gi]  = sel_arr[gi].hit;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_reg[a] <= '0;
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (sel_arr[a].hit) begin
          mem_reg[a] <= wd_arr[sel_arr[a].port];
        end
      end
    end
  end

  // Dropped zero-register writes are already masked out of we_eff, so a
  // double write to address 0 never flags.
  assign conflict_next = we_eff[0] && we_eff[MAX_WR-1] && (wa_arr[0] == wa_arr[MAX_WR-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_reg <= 1'b0;
    end else begin
      conflict_reg <= conflict_next;
    end
  end

  assign wr_conflict = conflict_reg;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_hit   (wr_hit),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Read ports with optional bypass from this cycle's writes.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra_i;
      logic [MAX_WR-1:0]     byp_hit;
      wr_sel_t               byp_sel;
      logic                  rsv_same;
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  busy_bit;

      assign ra_i     = ra[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign rsv_same = rsv_en && (rsv_addr == ra_i);

      always_comb begin
        byp_hit = '0;
        for (int j = 0; j < MAX_WR; j++) begin
          byp_hit[j] = we_eff[j] && (wa_arr[j] == ra_i);
        end
      end

      assign byp_sel = wr_winner(byp_hit);

      always_comb begin
        rd_data  = mem_reg[ra_i];
        busy_bit = busy[ra_i];
        if ((BYPASS != 0) && byp_sel.hit) begin
          rd_data = wd_arr[byp_sel.port];
          // The write completes the producer, unless a new reservation of the
          // same register arrives alongside it.
          if (!rsv_same) begin
            busy_bit = 1'b0;
          end
        end
        if ((ZERO_REG != 0) && (ra_i == '0)) begin
          rd_data  = '0;
          busy_bit = 1'b0;
        end
      end

      assign rd[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data;
      assign rd_busy[gi]                     = busy_bit;
    end
  endgenerate

endmodule
